cpu_sequencer: RTL and testbench

Multicycle instruction sequencer for the Harvard CPU control path. Steps each instruction through fetch, execute and optional data-memory phases, absorbing wait-states on both memory ports. Produces the single-cycle commit strobe that updates the program counter and branch logic, and the load strobe for the instruction register. Stops the core cleanly when the PC reports `finish`.

---
 rtl/cpu_seq_pkg.sv | 15 +
 rtl/seq_perf_counters.sv | 36 +++
 rtl/cpu_sequencer.sv | 124 ++++++++++++
 tb/tb_cpu_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared types and limits for the multicycle sequencer.
// Imported by cpu_sequencer and seq_perf_counters.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        HALTED = 3'd4
    } seq_state_t;

    localparam int unsigned SEQ_RESET_DELAY_MAX = 15;

endpackage

// File: rtl/seq_perf_counters.sv
// seq_perf_counters: busy-cycle, commit and stall counters, wrapping mod 2^32.
// Present only when CPU_SEQUENCER_PERF_EN is defined.
`ifdef CPU_SEQUENCER_PERF_EN
module seq_perf_counters (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_busy,
    input  logic        i_commit,
    input  logic        i_stall,
    output logic [31:0] o_cycle_count,
    output logic [31:0] o_instr_count,
    output logic [31:0] o_stall_count
);

    logic [31:0] r_cycle;
    logic [31:0] r_instr;
    logic [31:0] r_stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cycle <= '0;
            r_instr <= '0;
            r_stall <= '0;
        end else begin
            if (i_busy)   r_cycle <= r_cycle + 32'd1;
            if (i_commit) r_instr <= r_instr + 32'd1;
            if (i_stall)  r_stall <= r_stall + 32'd1;
        end
    end

    assign o_cycle_count = r_cycle;
    assign o_instr_count = r_instr;
    assign o_stall_count = r_stall;

endmodule
`endif

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: IDLE/FETCH/EXEC/MEM/HALTED control sequencer with wait-states.
// Optional perf counters under CPU_SEQUENCER_PERF_EN.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned RESET_DELAY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        finish,
    input  logic        instr_waitrequest,
    input  logic        mem_req,
    input  logic        data_waitrequest,
    output logic        instr_read,
    output logic        ir_load,
    output logic        data_enable,
    output logic        state,
    output logic        halted,
    output logic        busy
`ifdef CPU_SEQUENCER_PERF_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count,
    output logic [31:0] stall_count
`endif
);

    // Out-of-range delays are clamped to 1..SEQ_RESET_DELAY_MAX
    localparam int unsigned LP_DLY =
        (RESET_DELAY > SEQ_RESET_DELAY_MAX) ? SEQ_RESET_DELAY_MAX :
        (RESET_DELAY == 0) ? 1 : RESET_DELAY;
    localparam logic [3:0] LP_DLY_LAST = 4'(LP_DLY - 1);

    seq_state_t r_state;
    seq_state_t w_next;
    logic [3:0] r_dly;
    logic [3:0] w_dly_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_dly   <= '0;
        end else begin
            r_state <= w_next;
            r_dly   <= w_dly_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_dly_next  = r_dly;
        instr_read  = 1'b0;
        ir_load     = 1'b0;
        data_enable = 1'b0;
        state       = 1'b0;
        halted      = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_dly == LP_DLY_LAST) begin
                    w_next     = FETCH;
                    w_dly_next = '0;
                end else begin
                    w_dly_next = r_dly + 4'd1;
                end
            end
            FETCH: begin
                busy       = 1'b1;
                instr_read = !finish;
                // finish wins over a completing fetch
                if (finish) begin
                    w_next = HALTED;
                end else if (!instr_waitrequest) begin
                    ir_load = 1'b1;
                    w_next  = EXEC;
                end
            end
            EXEC: begin
                busy = 1'b1;
                if (mem_req) begin
                    w_next = MEM;
                end else begin
                    state  = 1'b1;
                    w_next = FETCH;
                end
            end
            MEM: begin
                busy        = 1'b1;
                data_enable = 1'b1;
                if (!data_waitrequest) begin
                    state  = 1'b1;
                    w_next = FETCH;
                end
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                w_next     = IDLE;
                w_dly_next = '0;
            end
        endcase
    end

`ifdef CPU_SEQUENCER_PERF_EN
    logic w_stall;

    assign w_stall =
        ((r_state == FETCH) && !finish && instr_waitrequest) ||
        ((r_state == MEM) && data_waitrequest);

    seq_perf_counters u_perf (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_busy        (busy),
        .i_commit      (state),
        .i_stall       (w_stall),
        .o_cycle_count (cycle_count),
        .o_instr_count (instr_count),
        .o_stall_count (stall_count)
    );
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench, per-cycle expected output vectors.
// Perf counter checks only when CPU_SEQUENCER_PERF_EN is defined.
module tb_cpu_sequencer;

    typedef struct packed {
        logic       fin;
        logic       iwr;
        logic       mreq;
        logic       dwr;
        logic [5:0] exp;
    } row_t;

    // {instr_read, ir_load, data_enable, state, halted, busy}
    localparam logic [5:0] O_IDLE = 6'b000000;
    localparam logic [5:0] F_GO   = 6'b110001;
    localparam logic [5:0] F_WT   = 6'b100001;
    localparam logic [5:0] F_FIN  = 6'b000001;
    localparam logic [5:0] EX_C   = 6'b000101;
    localparam logic [5:0] EX_M   = 6'b000001;
    localparam logic [5:0] M_WT   = 6'b001001;
    localparam logic [5:0] M_GO   = 6'b001101;
    localparam logic [5:0] HALT   = 6'b000010;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic finish = 1'b0;
    logic instr_waitrequest = 1'b0;
    logic mem_req = 1'b0;
    logic data_waitrequest = 1'b0;
    logic instr_read, ir_load, data_enable, state, halted, busy;
    logic [5:0] outs;
`ifdef CPU_SEQUENCER_PERF_EN
    logic [31:0] cycle_count, instr_count, stall_count;
`endif

    logic [5:0] sb[$];
    logic [5:0] e;
    int n_chk = 0;
    int n_pass = 0;
    bit aligned = 1'b0;
    logic [31:0] m_cyc = '0;
    logic [31:0] m_ins = '0;
    logic [31:0] m_stl = '0;

    assign outs = {instr_read, ir_load, data_enable, state, halted, busy};

    always #5 clk = ~clk;

    cpu_sequencer #(.RESET_DELAY(1)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .finish            (finish),
        .instr_waitrequest (instr_waitrequest),
        .mem_req           (mem_req),
        .data_waitrequest  (data_waitrequest),
        .instr_read        (instr_read),
        .ir_load           (ir_load),
        .data_enable       (data_enable),
        .state             (state),
        .halted            (halted),
        .busy              (busy)
`ifdef CPU_SEQUENCER_PERF_EN
        ,
        .cycle_count       (cycle_count),
        .instr_count       (instr_count),
        .stall_count       (stall_count)
`endif
    );

    function automatic row_t mk(input logic [3:0] in, input logic [5:0] ex);
        return row_t'({in, ex});
    endfunction

    task automatic drive(input row_t r);
        if (!aligned) begin
            @(posedge clk);
            #1;
        end
        aligned = 1'b0;
        finish = r.fin;
        instr_waitrequest = r.iwr;
        mem_req = r.mreq;
        data_waitrequest = r.dwr;
        sb.push_back(r.exp);
    endtask

    task automatic account(input row_t r);
        m_cyc += 32'(r.exp[0]);
        m_ins += 32'(r.exp[2]);
        m_stl += 32'((r.exp[5] & r.iwr) | (r.exp[3] & r.dwr));
    endtask

    task automatic test_reset;
        row_t rows[$];
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (outs !== 6'b0) $display("FAIL reset_outs got=%b exp=%b", outs, 6'b0);
        else n_pass++;
`ifdef CPU_SEQUENCER_PERF_EN
        n_chk++;
        if ({cycle_count, instr_count, stall_count} !== 96'b0)
            $display("FAIL reset_cnt got=%h/%h/%h exp=0", cycle_count, instr_count, stall_count);
        else n_pass++;
`endif
        reset_n = 1'b1;
        aligned = 1'b1;
        rows = '{mk(4'b0000, O_IDLE)};
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (outs !== e) $display("FAIL reset_idle[%0d] got=%b exp=%b", i, outs, e);
            else n_pass++;
            account(rows[i]);
        end
    endtask

    task automatic test_basic;
        row_t rows[$];
        rows = '{mk(4'b0000, F_GO), mk(4'b0000, EX_C),
                 mk(4'b0000, F_GO), mk(4'b0000, EX_C),
                 mk(4'b0000, F_GO), mk(4'b0000, EX_C)};
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (outs !== e) $display("FAIL basic[%0d] got=%b exp=%b", i, outs, e);
            else n_pass++;
            account(rows[i]);
        end
`ifdef CPU_SEQUENCER_PERF_EN
        @(posedge clk);
        #1;
        aligned = 1'b1;
        n_chk++;
        if (instr_count !== 32'd3 || cycle_count !== m_cyc)
            $display("FAIL basic_cnt got=%0d/%0d exp=3/%0d", instr_count, cycle_count, m_cyc);
        else n_pass++;
`endif
    endtask

    task automatic test_mem_wait;
        row_t rows[$];
        rows = '{mk(4'b0000, F_GO), mk(4'b0010, EX_M),
                 mk(4'b0011, M_WT), mk(4'b0011, M_WT),
                 mk(4'b0011, M_WT), mk(4'b0011, M_WT),
                 mk(4'b0010, M_GO)};
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (outs !== e) $display("FAIL mem_wait[%0d] got=%b exp=%b", i, outs, e);
            else n_pass++;
            account(rows[i]);
        end
`ifdef CPU_SEQUENCER_PERF_EN
        @(posedge clk);
        #1;
        aligned = 1'b1;
        n_chk++;
        if (stall_count !== 32'd4 || instr_count !== m_ins)
            $display("FAIL mem_cnt got=%0d/%0d exp=4/%0d", stall_count, instr_count, m_ins);
        else n_pass++;
`endif
    endtask

    task automatic test_fetch_wait;
        row_t rows[$];
        rows = '{mk(4'b0100, F_WT), mk(4'b0100, F_WT),
                 mk(4'b0100, F_WT), mk(4'b0000, F_GO),
                 mk(4'b0000, EX_C)};
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (outs !== e) $display("FAIL fetch_wait[%0d] got=%b exp=%b", i, outs, e);
            else n_pass++;
            account(rows[i]);
        end
    endtask

    task automatic test_back_to_back;
        row_t rows[$];
        rows = '{mk(4'b0011, F_GO), mk(4'b0101, EX_C),
                 mk(4'b0000, F_GO), mk(4'b0010, EX_M),
                 mk(4'b0000, M_GO)};
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (outs !== e) $display("FAIL b2b[%0d] got=%b exp=%b", i, outs, e);
            else n_pass++;
            account(rows[i]);
        end
`ifdef CPU_SEQUENCER_PERF_EN
        @(posedge clk);
        #1;
        aligned = 1'b1;
        n_chk++;
        if ({cycle_count, instr_count, stall_count} !== {m_cyc, m_ins, m_stl})
            $display("FAIL b2b_cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                     cycle_count, instr_count, stall_count, m_cyc, m_ins, m_stl);
        else n_pass++;
`endif
    endtask

`ifdef CPU_SEQUENCER_PERF_EN
    task automatic test_wrap;
        row_t rows[$];
        force dut.u_perf.r_cycle = 32'hFFFF_FFFE;
        #1;
        release dut.u_perf.r_cycle;
        m_cyc = 32'hFFFF_FFFE;
        aligned = 1'b1;
        rows = '{mk(4'b0000, F_GO), mk(4'b0000, EX_C)};
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (outs !== e) $display("FAIL wrap[%0d] got=%b exp=%b", i, outs, e);
            else n_pass++;
            account(rows[i]);
        end
        @(posedge clk);
        #1;
        aligned = 1'b1;
        n_chk++;
        if (cycle_count !== 32'd0) $display("FAIL wrap_cnt got=%h exp=0", cycle_count);
        else n_pass++;
    endtask
`endif

    task automatic test_finish;
        row_t rows[$];
        rows = '{mk(4'b1000, F_FIN), mk(4'b0000, HALT),
                 mk(4'b0101, HALT), mk(4'b1010, HALT)};
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (outs !== e) $display("FAIL finish[%0d] got=%b exp=%b", i, outs, e);
            else n_pass++;
            account(rows[i]);
        end
`ifdef CPU_SEQUENCER_PERF_EN
        @(posedge clk);
        #1;
        aligned = 1'b1;
        n_chk++;
        if ({cycle_count, instr_count, stall_count} !== {m_cyc, m_ins, m_stl})
            $display("FAIL frozen_cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                     cycle_count, instr_count, stall_count, m_cyc, m_ins, m_stl);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid;
        row_t rows[$];
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        n_chk++;
        if (outs !== 6'b0) $display("FAIL reset_halt got=%b exp=%b", outs, 6'b0);
        else n_pass++;
        m_cyc = '0;
        m_ins = '0;
        m_stl = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        aligned = 1'b1;
        rows = '{mk(4'b0000, O_IDLE), mk(4'b0000, F_GO),
                 mk(4'b0010, EX_M), mk(4'b0011, M_WT)};
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (outs !== e) $display("FAIL pre_mid[%0d] got=%b exp=%b", i, outs, e);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        data_waitrequest = 1'b0;
        reset_n = 1'b0;
        #1;
        n_chk++;
        if (outs !== 6'b0) $display("FAIL reset_mid_mem got=%b exp=%b", outs, 6'b0);
        else n_pass++;
`ifdef CPU_SEQUENCER_PERF_EN
        n_chk++;
        if ({cycle_count, instr_count, stall_count} !== 96'b0)
            $display("FAIL reset_mid_cnt got=%h/%h/%h exp=0", cycle_count, instr_count, stall_count);
        else n_pass++;
`endif
        @(posedge clk);
        #1;
        n_chk++;
        if (outs !== 6'b0) $display("FAIL reset_hold got=%b exp=%b", outs, 6'b0);
        else n_pass++;
        reset_n = 1'b1;
        aligned = 1'b1;
        rows = '{mk(4'b0000, O_IDLE), mk(4'b0000, F_GO), mk(4'b0000, EX_C)};
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (outs !== e) $display("FAIL post_mid[%0d] got=%b exp=%b", i, outs, e);
            else n_pass++;
            account(rows[i]);
        end
`ifdef CPU_SEQUENCER_PERF_EN
        @(posedge clk);
        #1;
        aligned = 1'b1;
        n_chk++;
        if ({cycle_count, instr_count, stall_count} !== {m_cyc, m_ins, m_stl})
            $display("FAIL post_mid_cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                     cycle_count, instr_count, stall_count, m_cyc, m_ins, m_stl);
        else n_pass++;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_mem_wait();
        test_fetch_wait();
        test_back_to_back();
`ifdef CPU_SEQUENCER_PERF_EN
        test_wrap();
`endif
        test_finish();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
